pixel_downloader: RTL and testbench

//  Write-side DMA, the counterpart of the pixel-upload path: drains 32-bit words from a pixel FIFO,

---
 rtl/pixel_downloader_if.sv | 28 ++
 rtl/pixel_downloader.sv | 174 +++++++++++++++++
 tb/tb_pixel_downloader.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_downloader_if.sv
// Memory-write master and pixel-FIFO read port of the pixel downloader, bundled for connection.
interface pixel_downloader_if;
  logic [32:0]  avl_mm_addr;
  logic         avl_mm_write;
  logic [255:0] avl_mm_writedata;
  logic [31:0]  avl_mm_byteenable;
  logic         avl_mm_waitrequest;
  logic         avl_mm_writeresponsevalid;
  logic [1:0]   avl_mm_response;
  logic         pix_fifo_read;
  logic [31:0]  pix_fifo_data;
  logic         pix_fifo_empty;
  logic [9:0]   pix_fifo_usedw;

  modport master (
    output avl_mm_addr, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
    input  avl_mm_waitrequest, avl_mm_writeresponsevalid, avl_mm_response,
    output pix_fifo_read,
    input  pix_fifo_data, pix_fifo_empty, pix_fifo_usedw
  );

  modport slave (
    input  avl_mm_addr, avl_mm_write, avl_mm_writedata, avl_mm_byteenable,
    output avl_mm_waitrequest, avl_mm_writeresponsevalid, avl_mm_response,
    input  pix_fifo_read,
    output pix_fifo_data, pix_fifo_empty, pix_fifo_usedw
  );
endinterface

// File: rtl/pixel_downloader.sv
// Write-side pixel DMA: drains 32-bit FIFO words, packs them (optionally 3->4 byte pixel
// expansion) into 256-bit beats and writes them to memory over an Avalon-MM write master.
module pixel_downloader #(
  parameter int RESP_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  pixel_downloader_if.master  bus,
  input  logic                enable,
  input  logic                word_mode,
  input  logic [31:0]         base_address,
  input  logic [31:0]         total_size,
  input  logic                transform_data,
  output logic                write_error_w,
  output logic                frame_done,
  output logic                active
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_RESP} state_t;

  localparam logic [15:0] TIMER_LAST = 16'(RESP_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic          r_enable_d;
  logic [31:0]   r_addr;
  logic [31:0]   r_base;
  logic [31:0]   r_end;
  logic          r_transform;
  logic          r_word_mode;
  logic [3:0]    r_issued;
  logic [3:0]    r_captured;
  logic          r_rd_pending;
  logic [31:0]   r_words [8];
  logic          r_err_sticky;
  logic [15:0]   r_timer;
  logic          r_frame_done;
  logic          r_write_error;

  logic [3:0]    w_n;
  logic [3:0]    w_n_idle;
  logic          w_fifo_read;
  logic          w_start;
  logic          w_advance;
  logic          w_error;
  logic [31:0]   w_addr_step;
  logic [191:0]  w_vec192;
  logic [255:0]  w_beat;

  assign w_n         = r_transform ? 4'd6 : 4'd8;
  assign w_n_idle    = transform_data ? 4'd6 : 4'd8;
  assign w_addr_step = r_addr + (r_word_mode ? 32'd8 : 32'd32);
  assign w_vec192    = {r_words[5], r_words[4], r_words[3], r_words[2], r_words[1], r_words[0]};

  // Transform mode slices the 192-bit word vector into eight 24-bit pixels, zero-padding byte 3.
  for (genvar gi = 0; gi < 8; gi++) begin : g_pack
    assign w_beat[32*gi +: 32] = r_transform ? {8'h00, w_vec192[24*gi +: 24]} : r_words[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fifo_read  = 1'b0;
    w_start      = 1'b0;
    w_advance    = 1'b0;
    w_error      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && !r_err_sticky && (bus.pix_fifo_usedw >= {6'd0, w_n_idle})) begin
          w_start      = 1'b1;
          w_state_next = S_COLLECT;
        end
      end
      S_COLLECT: begin
        w_fifo_read = (r_issued < w_n) && !bus.pix_fifo_empty;
        if (r_rd_pending && (r_captured == w_n - 4'd1)) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (!bus.avl_mm_waitrequest) begin
          if (RESP_TIMEOUT == 0) begin
            w_advance    = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_RESP;
          end
        end
      end
      S_RESP: begin
        if (bus.avl_mm_writeresponsevalid) begin
          if (bus.avl_mm_response == 2'b00) w_advance = 1'b1;
          else                              w_error   = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_timer == TIMER_LAST) begin
          w_error      = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enable_d    <= 1'b0;
      r_addr        <= '0;
      r_base        <= '0;
      r_end         <= '0;
      r_transform   <= 1'b0;
      r_word_mode   <= 1'b0;
      r_issued      <= '0;
      r_captured    <= '0;
      r_rd_pending  <= 1'b0;
      r_err_sticky  <= 1'b0;
      r_timer       <= '0;
      r_frame_done  <= 1'b0;
      r_write_error <= 1'b0;
      for (int i = 0; i < 8; i++) r_words[i] <= '0;
    end else begin
      r_enable_d    <= enable;
      r_rd_pending  <= w_fifo_read;
      r_frame_done  <= 1'b0;
      r_write_error <= 1'b0;

      if (w_start) begin
        r_transform <= transform_data;
        r_word_mode <= word_mode;
        r_issued    <= '0;
        r_captured  <= '0;
      end
      if (w_fifo_read) r_issued <= r_issued + 4'd1;
      // FIFO data lags the read strobe by one cycle, so capture on the delayed strobe.
      if (r_rd_pending) begin
        r_words[r_captured[2:0]] <= bus.pix_fifo_data;
        r_captured               <= r_captured + 4'd1;
      end

      if (r_state == S_RESP) r_timer <= r_timer + 16'd1;
      else                   r_timer <= '0;

      if (w_error) begin
        r_write_error <= 1'b1;
        r_err_sticky  <= 1'b1;
      end
      if (!enable) r_err_sticky <= 1'b0;

      if (enable && !r_enable_d) begin
        r_addr <= base_address;
        r_base <= base_address;
        r_end  <= base_address + total_size;
      end else if (w_advance) begin
        if (w_addr_step == r_end) begin
          r_addr       <= r_base;
          r_frame_done <= 1'b1;
        end else begin
          r_addr <= w_addr_step;
        end
      end
    end
  end

  assign bus.avl_mm_addr       = {1'b0, r_addr};
  assign bus.avl_mm_write      = (r_state == S_WRITE);
  assign bus.avl_mm_writedata  = w_beat;
  assign bus.avl_mm_byteenable = 32'hFFFF_FFFF;
  assign bus.pix_fifo_read     = w_fifo_read;
  assign write_error_w         = r_write_error;
  assign frame_done            = r_frame_done;
  assign active                = (r_state != S_IDLE);

endmodule

// File: tb/tb_pixel_downloader.sv
// Self-checking bench for pixel_downloader: FIFO model, Avalon slave with scoreboard, frame table.
module tb_pixel_downloader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pixel_downloader_if bus ();

  logic        enable = 1'b0;
  logic        word_mode = 1'b0;
  logic        transform_data = 1'b0;
  logic [31:0] base_address = '0;
  logic [31:0] total_size = '0;
  logic        write_error_w;
  logic        frame_done;
  logic        active;

  pixel_downloader #(.RESP_TIMEOUT(255)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .enable         (enable),
    .word_mode      (word_mode),
    .base_address   (base_address),
    .total_size     (total_size),
    .transform_data (transform_data),
    .write_error_w  (write_error_w),
    .frame_done     (frame_done),
    .active         (active)
  );

  typedef struct {
    logic [32:0]  addr;
    logic [255:0] data;
  } beat_t;

  typedef struct {
    bit          t;
    bit          wm;
    logic [31:0] base;
    logic [31:0] size;
    int          nb;
    bit          pat;
    logic [31:0] seed;
    int          exp_fd;
    logic [32:0] exp_addr;
  } vec_t;

  int vec_cnt = 0;
  int fail_cnt = 0;
  int writes = 0;
  int fd_count = 0;
  int err_count = 0;
  int rd_count = 0;
  int write_hi_cnt = 0;

  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [31:0] fifo_q[$];
  logic        q_empty = 1'b1;
  logic [9:0]  q_cnt = '0;
  logic        stall = 1'b0;
  logic [1:0]  resp_code = 2'b00;

  assign bus.pix_fifo_empty = q_empty | stall;
  assign bus.pix_fifo_usedw = q_cnt;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input int j);
    return 8'((j + 1) * 17);
  endfunction

  // Independent byte-wise reference for beat packing.
  function automatic logic [255:0] pack(input logic [255:0] raw, input bit t);
    logic [255:0] r;
    r = raw;
    if (t) begin
      r = '0;
      for (int p = 0; p < 8; p++)
        r[32*p +: 32] = {8'h00, raw[8*(3*p+2) +: 8], raw[8*(3*p+1) +: 8], raw[8*(3*p) +: 8]};
    end
    return r;
  endfunction

  task automatic push_word(input logic [31:0] w);
    fifo_q.push_back(w);
    q_cnt   = 10'(fifo_q.size());
    q_empty = 1'b0;
  endtask

  task automatic push_exp(input logic [32:0] a, input logic [255:0] d);
    beat_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.pix_fifo_read && fifo_q.size() != 0) begin
      bus.pix_fifo_data <= fifo_q.pop_front();
      q_cnt             <= 10'(fifo_q.size());
      q_empty           <= (fifo_q.size() == 0);
    end
  end

  // Slave monitor / responder, sampled 1 ns after the falling edge.
  initial begin
    bit resp_due;
    bit have_prev;
    logic [32:0]  prev_addr;
    logic [255:0] prev_data;
    resp_due  = 1'b0;
    have_prev = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    bus.avl_mm_writeresponsevalid = 1'b0;
    bus.avl_mm_response           = 2'b00;
    forever begin
      @(negedge clk);
      #1;
      bus.avl_mm_writeresponsevalid = 1'b0;
      bus.avl_mm_response           = 2'b00;
      if (resp_due) begin
        bus.avl_mm_writeresponsevalid = 1'b1;
        bus.avl_mm_response           = resp_code;
        resp_due = 1'b0;
      end
      if (frame_done)    fd_count++;
      if (write_error_w) err_count++;
      if (bus.pix_fifo_read) begin
        rd_count++;
        check("rd_not_empty", bus.pix_fifo_empty, 1'b0);
      end
      if (bus.avl_mm_write) begin
        write_hi_cnt++;
        if (have_prev) begin
          check("stall_addr", bus.avl_mm_addr, prev_addr);
          check("stall_data", bus.avl_mm_writedata, prev_data);
        end
        if (bus.avl_mm_waitrequest) begin
          have_prev = 1'b1;
          prev_addr = bus.avl_mm_addr;
          prev_data = bus.avl_mm_writedata;
        end else begin
          have_prev = 1'b0;
          writes++;
          resp_due = 1'b1;
          $display("write addr=%h data=%h", bus.avl_mm_addr, bus.avl_mm_writedata);
          if (exp_q.size() == 0) begin
            vec_cnt++;
            fail_cnt++;
            $display("FAIL unexpected_write: got addr %0h required no write", bus.avl_mm_addr);
          end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", bus.avl_mm_addr, mon_e.addr);
            check("wr_data", bus.avl_mm_writedata, mon_e.data);
          end
        end
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  task automatic run_frame(input bit t, input bit wm, input logic [31:0] base,
                           input logic [31:0] size, input int nb, input bit pat,
                           input logic [31:0] seed);
    logic [32:0]  a;
    logic [32:0]  nxt;
    logic [255:0] raw;
    logic [31:0]  w;
    int n;
    int wi;
    n  = t ? 6 : 8;
    a  = {1'b0, base};
    wi = 0;
    for (int b = 0; b < nb; b++) begin
      raw = '0;
      for (int k = 0; k < n; k++) begin
        if (pat) w = {byte_of(4*wi+3), byte_of(4*wi+2), byte_of(4*wi+1), byte_of(4*wi)};
        else     w = seed + 32'(wi);
        raw[32*k +: 32] = w;
        push_word(w);
        wi++;
      end
      push_exp(a, pack(raw, t));
      nxt = a + (wm ? 33'd8 : 33'd32);
      a   = (nxt == ({1'b0, base} + {1'b0, size})) ? {1'b0, base} : nxt;
    end
    transform_data = t;
    word_mode      = wm;
    base_address   = base;
    total_size     = size;
    enable         = 1'b1;
  endtask

  task automatic wait_writes(input int target, input string name);
    int c;
    c = 0;
    while (writes < target && c < 2000) begin
      @(negedge clk);
      #2;
      c++;
    end
    if (writes < target) begin
      vec_cnt++;
      fail_cnt++;
      $display("FAIL %s: timeout with %0d writes, required %0d", name, writes, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      #2;
      c++;
    end while (active && c < 2000);
    if (active) begin
      vec_cnt++;
      fail_cnt++;
      $display("FAIL %s: timeout with active=%0d, required 0", name, active);
    end
  endtask

  task automatic wait_signal(input bit want_read, input string name);
    int c;
    bit seen;
    c = 0;
    seen = 1'b0;
    while (!seen && c < 2000) begin
      @(negedge clk);
      #2;
      seen = want_read ? bus.pix_fifo_read : bus.avl_mm_write;
      c++;
    end
    if (!seen) begin
      vec_cnt++;
      fail_cnt++;
      $display("FAIL %s: timeout, signal never seen, required high", name);
    end
  endtask

  vec_t tbl[4];

  initial begin
    int w0, fd0, e0, r0, h0;
    logic [255:0] raw;

    tbl[0] = '{t:1'b0, wm:1'b0, base:32'h1000, size:32'd64, nb:2, pat:1'b0, seed:32'h0,
               exp_fd:1, exp_addr:33'h1000};
    tbl[1] = '{t:1'b1, wm:1'b0, base:32'h2000, size:32'd96, nb:2, pat:1'b1, seed:32'h0,
               exp_fd:0, exp_addr:33'h2040};
    tbl[2] = '{t:1'b0, wm:1'b1, base:32'h1000, size:32'd16, nb:3, pat:1'b0, seed:32'h100,
               exp_fd:1, exp_addr:33'h1008};
    tbl[3] = '{t:1'b1, wm:1'b1, base:32'h3000, size:32'd8, nb:2, pat:1'b1, seed:32'h0,
               exp_fd:2, exp_addr:33'h3000};

    bus.avl_mm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_addr", bus.avl_mm_addr, 33'h0);
    check("rst_write", bus.avl_mm_write, 1'b0);
    check("rst_wdata", bus.avl_mm_writedata, 256'h0);
    check("rst_read", bus.pix_fifo_read, 1'b0);
    check("rst_active", active, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_error", write_error_w, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      w0  = writes;
      fd0 = fd_count;
      run_frame(tbl[i].t, tbl[i].wm, tbl[i].base, tbl[i].size, tbl[i].nb, tbl[i].pat, tbl[i].seed);
      wait_writes(w0 + tbl[i].nb, "vec_writes");
      wait_idle("vec_idle");
      check("vec_frame_done", 32'(fd_count - fd0), 32'(tbl[i].exp_fd));
      check("vec_final_addr", bus.avl_mm_addr, tbl[i].exp_addr);
      check("vec_sb_empty", 32'(exp_q.size()), 32'd0);
      enable = 1'b0;
      repeat (3) @(negedge clk);
    end

    // Slave stall: 5 waitrequest cycles keep the request up for 6 cycles.
    w0 = writes;
    h0 = write_hi_cnt;
    bus.avl_mm_waitrequest = 1'b1;
    run_frame(1'b0, 1'b0, 32'h4000, 32'h100, 1, 1'b0, 32'h500);
    wait_signal(1'b0, "stall_write_seen");
    repeat (5) @(negedge clk);
    bus.avl_mm_waitrequest = 1'b0;
    wait_idle("stall_idle");
    check("stall_write_cycles", 32'(write_hi_cnt - h0), 32'd6);
    check("stall_beats", 32'(writes - w0), 32'd1);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Error response: beat accepted, address kept, no further writes until enable toggles.
    w0  = writes;
    e0  = err_count;
    fd0 = fd_count;
    resp_code = 2'b10;
    run_frame(1'b0, 1'b0, 32'h5000, 32'h100, 1, 1'b0, 32'h600);
    raw = '0;
    for (int k = 0; k < 8; k++) begin
      push_word(32'h700 + 32'(k));
      raw[32*k +: 32] = 32'h700 + 32'(k);
    end
    wait_writes(w0 + 1, "err_first_write");
    wait_idle("err_idle");
    resp_code = 2'b00;
    repeat (30) @(negedge clk);
    check("err_pulses", 32'(err_count - e0), 32'd1);
    check("err_no_more_writes", 32'(writes - w0), 32'd1);
    check("err_addr_kept", bus.avl_mm_addr, 33'h5000);
    check("err_held_idle", active, 1'b0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    push_exp(33'h5000, raw);
    enable = 1'b1;
    wait_writes(w0 + 2, "err_recover_write");
    wait_idle("err_recover_idle");
    check("err_recover_addr", bus.avl_mm_addr, 33'h5020);
    check("err_no_frame_done", 32'(fd_count - fd0), 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // FIFO empty for 3 cycles mid-collect: reads pause and resume, order kept.
    w0 = writes;
    r0 = rd_count;
    run_frame(1'b0, 1'b0, 32'h6000, 32'h100, 1, 1'b0, 32'h800);
    wait_signal(1'b1, "empty_read_seen");
    @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_writes(w0 + 1, "empty_write");
    wait_idle("empty_idle");
    check("empty_read_count", 32'(rd_count - r0), 32'd8);
    check("empty_fifo_drained", 32'(fifo_q.size()), 32'd0);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end

endmodule
